// File: rtl/jk_stimulus_checker.sv
// Self-test driver for a JK flop: runs an 8-step preset/clear/hold/set/reset/toggle
// program, checks Q/Qbar against a reference bit and keeps pass/fail tallies.
//
// state  | meaning
// IDLE   | idle drive, waiting for start
// APPLY  | one cycle driving the current step's J/K/preset/clear vector
// SETTLE | idle drive for SETTLE_CYCLES cycles so the flop output settles
// CHECK  | compare q/qbar against the expected bit, advance step/loop
// DONE   | run finished, results held until the next start
module jk_stimulus_checker #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 8,
  parameter int LOOPS         = 1
) (
  input  logic             input_clock1_c_1,
  input  logic             input_reset_n_2,
  input  logic             start,
  input  logic             q,
  input  logic             qbar,
  output logic             j,
  output logic             k,
  output logic             preset_n,
  output logic             clear_n,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             fail_flag,
  output logic [2:0]       first_fail_step
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [3:0] IDLE_DRV = 4'b0011;  // {j, k, preset_n, clear_n}

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

  state_t          state;
  logic [2:0]      step;
  logic [LW-1:0]   loop_cnt;
  logic [SW-1:0]   settle_cnt;
  logic            exp_q;
  logic            check_ok;

  function automatic logic [3:0] step_drive(input logic [2:0] s);
    case (s)
      3'd0:       step_drive = 4'b0001;
      3'd1:       step_drive = 4'b0010;
      3'd3:       step_drive = 4'b1011;
      3'd5:       step_drive = 4'b0111;
      3'd6, 3'd7: step_drive = 4'b1111;
      default:    step_drive = IDLE_DRV;
    endcase
  endfunction

  function automatic logic next_exp(input logic [2:0] s, input logic e);
    case (s)
      3'd0, 3'd3: next_exp = 1'b1;
      3'd1, 3'd5: next_exp = 1'b0;
      3'd6, 3'd7: next_exp = ~e;
      default:    next_exp = e;
    endcase
  endfunction

  assign check_ok = (q == exp_q) && (qbar == ~exp_q);

  always_ff @(posedge input_clock1_c_1 or negedge input_reset_n_2) begin
    if (!input_reset_n_2) begin
      state                       <= IDLE;
      step                        <= 3'd0;
      loop_cnt                    <= '0;
      settle_cnt                  <= '0;
      exp_q                       <= 1'b0;
      {j, k, preset_n, clear_n}   <= IDLE_DRV;
      busy                        <= 1'b0;
      done                        <= 1'b0;
      pass_count                  <= '0;
      fail_count                  <= '0;
      fail_flag                   <= 1'b0;
      first_fail_step             <= 3'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_count                <= '0;
            fail_count                <= '0;
            fail_flag                 <= 1'b0;
            first_fail_step           <= 3'd0;
            step                      <= 3'd0;
            loop_cnt                  <= '0;
            {j, k, preset_n, clear_n} <= step_drive(3'd0);
            busy                      <= 1'b1;
            done                      <= 1'b0;
            state                     <= APPLY;
          end
        end
        APPLY: begin
          exp_q                     <= next_exp(step, exp_q);
          {j, k, preset_n, clear_n} <= IDLE_DRV;
          settle_cnt                <= SW'(SETTLE_CYCLES - 1);
          state                     <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 1'b1;
        end
        CHECK: begin
          if (check_ok) begin
            if (pass_count != '1) pass_count <= pass_count + 1'b1;
          end else begin
            if (fail_count != '1) fail_count <= fail_count + 1'b1;
            if (!fail_flag) begin
              fail_flag       <= 1'b1;
              first_fail_step <= step;
            end
          end
          if (step != 3'd7) begin
            step                      <= step + 3'd1;
            {j, k, preset_n, clear_n} <= step_drive(step + 3'd1);
            state                     <= APPLY;
          end else if (loop_cnt != LW'(LOOPS - 1)) begin
            step                      <= 3'd0;
            loop_cnt                  <= loop_cnt + 1'b1;
            {j, k, preset_n, clear_n} <= step_drive(3'd0);
            state                     <= APPLY;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_stimulus_checker.sv
// Bench for jk_stimulus_checker: a behavioural JK flop or injected Q/Qbar patterns
// on the input side, with expected drive and tallies computed from the step table.
module tb_jk_stimulus_checker;

  localparam int S = 2;
  localparam int STEP_LEN = S + 2;
  localparam int N_RUN = 8 * STEP_LEN;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start_b;
  int   mode;
  logic rq, rqb;

  logic j, k, preset_n, clear_n, busy, done, fail_flag;
  logic [7:0] pass_count, fail_count;
  logic [2:0] first_fail_step;
  logic fq, q_in, qbar_in;

  logic j_b, k_b, preset_n_b, clear_n_b, busy_b, done_b, fail_flag_b;
  logic [7:0] pass_count_b, fail_count_b;
  logic [2:0] first_fail_step_b;
  logic fq_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  jk_stimulus_checker dut (
    .input_clock1_c_1(clk), .input_reset_n_2(rst_n), .start(start),
    .q(q_in), .qbar(qbar_in), .j(j), .k(k), .preset_n(preset_n), .clear_n(clear_n),
    .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count),
    .fail_flag(fail_flag), .first_fail_step(first_fail_step)
  );

  jk_stimulus_checker #(.SETTLE_CYCLES(1), .CNT_W(8), .LOOPS(3)) dut_b (
    .input_clock1_c_1(clk), .input_reset_n_2(rst_n), .start(start_b),
    .q(fq_b), .qbar(~fq_b), .j(j_b), .k(k_b), .preset_n(preset_n_b), .clear_n(clear_n_b),
    .busy(busy_b), .done(done_b), .pass_count(pass_count_b), .fail_count(fail_count_b),
    .fail_flag(fail_flag_b), .first_fail_step(first_fail_step_b)
  );

  // Behavioural JK flops with async preset/clear (preset wins).
  always @(posedge clk or negedge preset_n or negedge clear_n) begin
    if (!preset_n)     fq <= 1'b1;
    else if (!clear_n) fq <= 1'b0;
    else case ({j, k})
      2'b01:   fq <= 1'b0;
      2'b10:   fq <= 1'b1;
      2'b11:   fq <= ~fq;
      default: fq <= fq;
    endcase
  end

  always @(posedge clk or negedge preset_n_b or negedge clear_n_b) begin
    if (!preset_n_b)     fq_b <= 1'b1;
    else if (!clear_n_b) fq_b <= 1'b0;
    else case ({j_b, k_b})
      2'b01:   fq_b <= 1'b0;
      2'b10:   fq_b <= 1'b1;
      2'b11:   fq_b <= ~fq_b;
      default: fq_b <= fq_b;
    endcase
  end

  // 0: correct flop, 1: q=0/qbar=1, 2: q=qbar=1, 3: random q/qbar every cycle
  assign q_in    = (mode == 1) ? 1'b0 : (mode == 2) ? 1'b1 : (mode == 3) ? rq  : fq;
  assign qbar_in = (mode == 1) ? 1'b1 : (mode == 2) ? 1'b1 : (mode == 3) ? rqb : ~fq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // {j, k, preset_n, clear_n} during each step's APPLY cycle
  function automatic logic [3:0] drive_of(input int st);
    case (st)
      0: return 4'b0001;
      1: return 4'b0010;
      3: return 4'b1011;
      5: return 4'b0111;
      6, 7: return 4'b1111;
      default: return 4'b0011;
    endcase
  endfunction

  task automatic do_run(input int m, input int restart_at);
    logic exp_seq [8];
    int exp_pass, exp_fail, ff, phase, st;
    logic ok;
    exp_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    exp_pass = 0; exp_fail = 0; ff = -1;
    mode = m;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < N_RUN; c++) begin
      phase = c % STEP_LEN;
      st = (c / STEP_LEN) % 8;
      start = (c == restart_at);
      if (m == 3) {rq, rqb} = 2'($urandom);
      if (c == 0) begin
        chk("clr_pass", 32'(pass_count), 32'd0);
        chk("clr_fail", 32'(fail_count), 32'd0);
      end
      chk("busy", 32'(busy), 32'd1);
      chk("done_early", 32'(done), 32'd0);
      chk("drive", 32'({j, k, preset_n, clear_n}), 32'(phase == 0 ? drive_of(st) : 4'b0011));
      #1;
      if (phase == S + 1) begin
        if (m == 0) chk("flop_q", 32'(q_in), 32'(exp_seq[st]));
        ok = (q_in == exp_seq[st]) && (qbar_in == ~exp_seq[st]);
        if (ok) exp_pass++;
        else begin
          exp_fail++;
          if (ff < 0) ff = st;
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done", 32'(done), 32'd1);
    chk("busy_end", 32'(busy), 32'd0);
    chk("pass_count", 32'(pass_count), 32'(exp_pass));
    chk("fail_count", 32'(fail_count), 32'(exp_fail));
    chk("fail_flag", 32'(fail_flag), 32'(exp_fail != 0));
    chk("first_fail_step", 32'(first_fail_step), 32'(ff < 0 ? 0 : ff));
    chk("idle_drive", 32'({j, k, preset_n, clear_n}), 32'h3);
    if (m == 0) chk("pass_all", 32'(pass_count), 32'd8);
    if (m == 1) chk("pass_stuck0", 32'(pass_count), 32'd4);
    if (m == 2) chk("fail_noncomp", 32'(fail_count), 32'd8);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; mode = 0; rq = 1'b0; rqb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drive", 32'({j, k, preset_n, clear_n}), 32'h3);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass_count), 32'd0);
    chk("rst_flag", 32'(fail_flag), 32'd0);
    rst_n = 1'b1;

    do_run(0, -1);
    repeat (3) @(posedge clk);
    #1 chk("done_hold", 32'(done), 32'd1);
    do_run(1, -1);
    do_run(2, -1);
    do_run(0, 5);
    for (int r = 0; r < 4; r++) do_run(3, -1);

    // Reset mid-run: abandoned immediately, no activity until next start
    mode = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_drive", 32'({j, k, preset_n, clear_n}), 32'h3);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_pass", 32'(pass_count), 32'd0);
    chk("mrst_fail", 32'(fail_count), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", 32'(busy), 32'd0);
      chk("post_rst_drive", 32'({j, k, preset_n, clear_n}), 32'h3);
    end
    do_run(0, -1);

    // LOOPS=3, SETTLE_CYCLES=1 instance: 72 edges, 24 passes
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int c = 0; c < 72; c++) begin
      chk("b_busy", 32'(busy_b), 32'd1);
      chk("b_done_early", 32'(done_b), 32'd0);
      @(posedge clk); #1;
    end
    chk("b_done", 32'(done_b), 32'd1);
    chk("b_pass", 32'(pass_count_b), 32'd24);
    chk("b_fail", 32'(fail_count_b), 32'd0);
    chk("b_flag", 32'(fail_flag_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Async preset and clear must never be asserted together.
  always @(negedge clk) begin
    if (!preset_n && !clear_n) chk("preset_clear_overlap", 32'd1, 32'd0);
  end

endmodule

// File: doc/jk_stimulus_checker.md
Name: jk_stimulus_checker

Overview:
- Synthesizable stimulus driver and response checker for the JK flip-flop block; it is the driving end of the flop's J/K/preset/clear interface.
- Runs a fixed 8-step program of async preset, async clear, hold, set, reset and toggle operations.
- Samples Q/Qbar, compares them against an internal reference model, and accumulates pass/fail counts.
- Sits beside the flop on the same clock and enables on-board self-test without a simulator.

Parameters:
- SETTLE_CYCLES, 2: idle cycles between applying a step and sampling it; legal range ≥1.
- CNT_W, 8: width of the pass/fail counters.
- LOOPS, 1: number of times the 8-step program repeats per start; legal range ≥1.

Ports:
- input_clock1_c_1  in  1  Clock shared with the flop under test.
- input_reset_n_2  in  1  Reset, asynchronous, active-low.
- start  in  1  Single-cycle start request; sampled only in IDLE or DONE.
- q  in  1  Q from the flop.
- qbar  in  1  Qbar from the flop.
- j  out  1  J drive.
- k  out  1  K drive.
- preset_n  out  1  Async preset drive, active-low.
- clear_n  out  1  Async clear drive, active-low.
- busy  out  1  High in APPLY, SETTLE and CHECK.
- done  out  1  High in DONE.
- pass_count  out  CNT_W  Number of passing checks.
- fail_count  out  CNT_W  Number of failing checks.
- fail_flag  out  1  Sticky; set on the first failing check.
- first_fail_step  out  3  Step index of the first failure.

Behaviour:
- All outputs are registered.
- Reset value, and idle drive in IDLE/SETTLE/DONE:
  - j=0, k=0, preset_n=1, clear_n=1.
  - busy=0, done=0, counters=0, fail_flag=0, first_fail_step=0.
- Reset assertion at any time forces IDLE and these values immediately. A run in progress is abandoned and never resumes.
- States: IDLE, APPLY, SETTLE, CHECK, DONE.
- IDLE/DONE, start=1:
  - clear pass_count, fail_count, fail_flag, first_fail_step; step=0, loop=0; go to APPLY.
  - In DONE without start, done stays high.
- APPLY (1 cycle) drives the step vector below. For J/K steps the flop captures on the edge that ends APPLY. Next state: SETTLE.
- SETTLE holds the idle drive for exactly SETTLE_CYCLES cycles, then goes to CHECK.
- CHECK (1 cycle):
  - Pass iff q==exp and qbar==~exp. Increment pass_count or fail_count; both saturate at 2^CNT_W-1.
  - On the first failure: fail_flag=1, first_fail_step=step.
  - If step<7: step+1, go to APPLY.
  - If step==7 and loop<LOOPS-1: step=0, loop+1, go to APPLY.
  - Otherwise go to DONE.
- The exp model updates in APPLY per the step's operation.
- Program (step: drive -> exp):
  - 0: preset_n=0 -> 1
  - 1: clear_n=0 -> 0
  - 2: j=0, k=0 (hold) -> exp
  - 3: j=1, k=0 -> 1
  - 4: j=0, k=0 -> exp
  - 5: j=0, k=1 -> 0
  - 6: j=1, k=1 -> ~exp
  - 7: j=1, k=1 -> ~exp
- Expected sequence for a correct flop: 1,0,0,1,1,0,1,0.
- Timing:
  - Each step takes SETTLE_CYCLES+2 cycles.
  - done rises exactly LOOPS*8*(SETTLE_CYCLES+2) rising edges after the edge that samples start. This is 32 edges with default parameters.
- start is ignored while busy=1.
- start in DONE restarts the run with counters cleared.
- Asynchronous preset and clear are never asserted together; only one of preset_n and clear_n is ever 0 in any cycle.

Test Plan:
- Defaults with a correct JK flop, start pulse -> done after 32 edges; pass_count=8, fail_count=0, fail_flag=0. Drive trace shows preset_n=0 in step 0 and clear_n=0 in step 1.
- q tied 0, qbar tied 1 -> pass_count=4, fail_count=4 (steps 0,3,4,6 fail); fail_flag=1, first_fail_step=0.
- q=qbar=1 (non-complementary) -> fail_count=8, pass_count=0, first_fail_step=0.
- LOOPS=3, SETTLE_CYCLES=1, correct flop -> done after 72 edges, pass_count=24.
- Reset pulse at edge 10 of a run -> j=k=0, preset_n=clear_n=1, counters=0, busy=0 immediately. No activity until the next start; a subsequent run gives pass_count=8.
- Start re-pulsed at edge 5 (busy) -> ignored, done at edge 32. Start in DONE -> counters clear, done drops, rerun completes with pass_count=8.
